// File: rtl/systolic_feeder.sv
// systolic_feeder: holds host-written A/B matrices and streams skewed operands into a PE array,
// one load_out beat at a time, each beat waiting for done_in before the next is issued.
module systolic_feeder #(
    parameter int N  = 2,
    parameter int DW = 2,
    parameter int AW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    input  logic            done_in,
    output logic            busy,
    output logic            array_rst,
    output logic            load_out,
    output logic [N*DW-1:0] row_bus,
    output logic [N*DW-1:0] col_bus,
    output logic            feed_done
);
    localparam int BEATS = 3 * N - 2;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int IW    = $clog2(N * N);

    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, FIN} state_t;

    state_t          state;
    logic [DW-1:0]   mem_a [N*N];
    logic [DW-1:0]   mem_b [N*N];
    logic [CW-1:0]   t;
    logic [CW-1:0]   t_nxt;
    logic [N*DW-1:0] row_nxt;
    logic [N*DW-1:0] col_nxt;

    always_ff @(posedge clk) begin
        if (wr_en && !busy && int'(wr_addr) < N * N) begin
            if (wr_sel) mem_b[IW'(wr_addr)] <= wr_data;
            else        mem_a[IW'(wr_addr)] <= wr_data;
        end
    end

    // Operands for the beat about to be issued: beat 0 from CLR, t+1 from WAIT.
    assign t_nxt = (state == CLR) ? '0 : t + CW'(1);

    always_comb begin
        row_nxt = '0;
        col_nxt = '0;
        for (int i = 0; i < N; i++) begin
            row_nxt[i*DW +: DW] = (int'(t_nxt) >= i && int'(t_nxt) - i < N) ?
                                  mem_a[IW'(i * N + int'(t_nxt) - i)] : '0;
            col_nxt[i*DW +: DW] = (int'(t_nxt) >= i && int'(t_nxt) - i < N) ?
                                  mem_b[IW'((int'(t_nxt) - i) * N + i)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            busy      <= 1'b0;
            array_rst <= 1'b0;
            load_out  <= 1'b0;
            feed_done <= 1'b0;
            row_bus   <= '0;
            col_bus   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= CLR;
                    busy      <= 1'b1;
                    array_rst <= 1'b1;
                    row_bus   <= '0;
                    col_bus   <= '0;
                end
                CLR: begin
                    state     <= ISSUE;
                    t         <= '0;
                    array_rst <= 1'b0;
                    load_out  <= 1'b1;
                    row_bus   <= row_nxt;
                    col_bus   <= col_nxt;
                end
                ISSUE: begin
                    state    <= WAIT;
                    load_out <= 1'b0;
                end
                WAIT: if (done_in) begin
                    if (t == CW'(BEATS - 1)) begin
                        state     <= FIN;
                        feed_done <= 1'b1;
                        row_bus   <= '0;
                        col_bus   <= '0;
                    end else begin
                        state    <= ISSUE;
                        t        <= t_nxt;
                        load_out <= 1'b1;
                        row_bus  <= row_nxt;
                        col_bus  <= col_nxt;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    feed_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed per-cycle vector tables for N=2, DW=2 feeds,
// A=[[1,2],[3,0]], B=[[2,1],[1,3]].
module tb_systolic_feeder;
    logic       clk = 1'b0;
    logic       rst, wr_en, wr_sel, start, done_in;
    logic [1:0] wr_addr, wr_data;
    logic       busy, array_rst, load_out, feed_done;
    logic [3:0] row_bus, col_bus;
    int         total = 0;
    int         bad = 0;
    int         loads = 0;

    typedef struct {
        logic        r, s, d, w;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[$];

    systolic_feeder #(.N(2), .DW(2), .AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .done_in(done_in), .busy(busy),
        .array_rst(array_rst), .load_out(load_out), .row_bus(row_bus),
        .col_bus(col_bus), .feed_done(feed_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (load_out) loads++;

    // Expected output word: {busy, array_rst, load_out, feed_done, row_bus, col_bus}
    function automatic logic [11:0] o(input logic b, a, l, f, input logic [3:0] rw, cl);
        return {b, a, l, f, rw, cl};
    endfunction
    function automatic logic [11:0] o_clr();
        return o(1, 1, 0, 0, 4'h0, 4'h0);
    endfunction
    function automatic logic [11:0] o_iss(input logic [3:0] rw, cl);
        return o(1, 0, 1, 0, rw, cl);
    endfunction
    function automatic logic [11:0] o_wt(input logic [3:0] rw, cl);
        return o(1, 0, 0, 0, rw, cl);
    endfunction
    function automatic logic [11:0] o_fin();
        return o(1, 0, 0, 1, 4'h0, 4'h0);
    endfunction

    task automatic add(input logic r, s, d, w, input logic [11:0] e);
        vec_t v;
        v.r = r; v.s = s; v.d = d; v.w = w; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {busy, array_rst, load_out, feed_done, row_bus, col_bus};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got b/ar/ld/fd=%b row=%b col=%b, want b/ar/ld/fd=%b row=%b col=%b",
                     name, act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    // Busy-time writes target A[0][0] with 3, which must never reach the buses.
    task automatic run_tbl(input string name);
        foreach (tbl[k]) begin
            rst = tbl[k].r; start = tbl[k].s; done_in = tbl[k].d;
            wr_en = tbl[k].w; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 2'd3;
            @(posedge clk); #1;
            check($sformatf("%s[%0d]", name, k), tbl[k].exp);
        end
        tbl.delete();
        rst = 0; start = 0; done_in = 0; wr_en = 0;
    endtask

    task automatic std_feed(input logic sw);
        add(0, 1, 1, 0, o_clr());
        add(0, sw, 1, sw, o_iss(4'b0001, 4'b0010));
        add(0, sw, 1, sw, o_wt(4'b0001, 4'b0010));
        add(0, sw, 1, sw, o_iss(4'b1110, 4'b0101));
        add(0, sw, 1, sw, o_wt(4'b1110, 4'b0101));
        add(0, sw, 1, sw, o_iss(4'b0000, 4'b1100));
        add(0, sw, 1, sw, o_wt(4'b0000, 4'b1100));
        add(0, sw, 1, sw, o_iss(4'b0000, 4'b0000));
        add(0, sw, 1, sw, o_wt(4'b0000, 4'b0000));
        add(0, sw, 1, sw, o_fin());
        add(0, 0, 1, 0, 12'h000);
    endtask

    task automatic wr(input logic sel, input logic [1:0] a, input logic [1:0] d);
        wr_en = 1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    initial begin
        rst = 1; start = 0; done_in = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 12'h000);
        rst = 0;
        wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 0);
        wr(1, 0, 2); wr(1, 1, 1); wr(1, 2, 1); wr(1, 3, 3);
        check("idle_after_writes", 12'h000);

        std_feed(0);
        run_tbl("feed");

        // done_in low for five WAIT cycles inside beat 1
        add(0, 1, 1, 0, o_clr());
        add(0, 0, 1, 0, o_iss(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_wt(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_iss(4'b1110, 4'b0101));
        add(0, 0, 0, 0, o_wt(4'b1110, 4'b0101));
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, o_wt(4'b1110, 4'b0101));
        add(0, 0, 1, 0, o_iss(4'b0000, 4'b1100));
        add(0, 0, 1, 0, o_wt(4'b0000, 4'b1100));
        add(0, 0, 1, 0, o_iss(4'b0000, 4'b0000));
        add(0, 0, 1, 0, o_wt(4'b0000, 4'b0000));
        add(0, 0, 1, 0, o_fin());
        add(0, 0, 1, 0, 12'h000);
        run_tbl("stall");

        // start and writes while busy are dropped; replay must be identical
        std_feed(1);
        run_tbl("busy_ign");
        std_feed(0);
        run_tbl("replay");

        // reset in WAIT of beat 2, then a full fresh feed
        add(0, 1, 1, 0, o_clr());
        add(0, 0, 1, 0, o_iss(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_wt(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_iss(4'b1110, 4'b0101));
        add(0, 0, 1, 0, o_wt(4'b1110, 4'b0101));
        add(0, 0, 1, 0, o_iss(4'b0000, 4'b1100));
        add(0, 0, 0, 0, o_wt(4'b0000, 4'b1100));
        add(1, 0, 1, 0, 12'h000);
        add(0, 0, 0, 0, 12'h000);
        run_tbl("midrst");
        std_feed(0);
        run_tbl("after_rst");

        // last of two back-to-back writes wins
        wr(1, 3, 2); wr(1, 3, 3);
        std_feed(0);
        run_tbl("rewrite");

        // done_in high only outside WAIT or late in WAIT: exactly four beats
        loads = 0;
        add(0, 1, 1, 0, o_clr());
        add(0, 0, 1, 0, o_iss(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_wt(4'b0001, 4'b0010));
        add(0, 0, 0, 0, o_wt(4'b0001, 4'b0010));
        add(0, 0, 1, 0, o_iss(4'b1110, 4'b0101));
        add(0, 0, 1, 0, o_wt(4'b1110, 4'b0101));
        add(0, 0, 0, 0, o_wt(4'b1110, 4'b0101));
        add(0, 0, 1, 0, o_iss(4'b0000, 4'b1100));
        add(0, 0, 1, 0, o_wt(4'b0000, 4'b1100));
        add(0, 0, 1, 0, o_iss(4'b0000, 4'b0000));
        add(0, 0, 1, 0, o_wt(4'b0000, 4'b0000));
        add(0, 0, 1, 0, o_fin());
        add(0, 0, 1, 0, 12'h000);
        add(0, 0, 1, 0, 12'h000);
        run_tbl("done_glitch");
        total++;
        if (loads != 4) begin
            bad++;
            $display("FAIL load_count: got %0d want 4", loads);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
